// File: rtl/uart_pkg.sv
// Shared UART types.
// State encoding for the transmit core.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_core.sv
// UART transmitter fed by a first-word-fall-through FIFO.
// Frame config is latched per word at pop time.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_tx_en,
  input  logic [DIV_W-1:0] i_baud_div,
  input  logic             i_parity_en,
  input  logic             i_parity_odd,
  input  logic             i_two_stop,
  input  logic             i_fifo_valid,
  input  logic [DW-1:0]    i_fifo_data,
  input  logic             i_fifo_parity_error,
  output logic             o_fifo_rd_req,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_drop
);

  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  uart_tx_state_t state_q, state_d;

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] baud_q, baud_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [DW-1:0]    data_q;
  logic             par_en_q;
  logic             par_odd_q;
  logic             two_stop_q;
  logic             tx_q, tx_d;
  logic             done_q;
  logic             drop_q;

  logic bit_end;
  logic last_data;
  logic last_stop;
  logic rd_req;
  logic pop_ok;
  logic pop_bad;

  assign bit_end   = (baud_q == div_q);
  assign last_data = (bit_q == BW'(DW - 1));

  // bit_q doubles as the stop-bit index
  assign last_stop = (state_q == STOP) && bit_end
                   && (!two_stop_q || bit_q[0]);

  assign rd_req  = i_nrst && i_tx_en && i_fifo_valid
                 && ((state_q == IDLE) || last_stop);
  assign pop_ok  = rd_req && !i_fifo_parity_error;
  assign pop_bad = rd_req && i_fifo_parity_error;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    baud_d  = bit_end ? '0 : baud_q + DIV_W'(1);
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (pop_ok) state_d = START;
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (last_data) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (last_stop) begin
          bit_d   = '0;
          state_d = pop_ok ? START : IDLE;
        end else if (bit_end) begin
          bit_d = bit_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        bit_d   = '0;
        baud_d  = '0;
      end
    endcase
  end

  always_comb begin
    tx_d = LINE_IDLE;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[bit_d];
      PARITY:  tx_d = (^data_q) ^ par_odd_q;
      default: tx_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= LINE_IDLE;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      done_q  <= last_stop;
      drop_q  <= pop_bad;
      if (pop_ok) begin
        data_q     <= i_fifo_data;
        div_q      <= i_baud_div;
        par_en_q   <= i_parity_en;
        par_odd_q  <= i_parity_odd;
        two_stop_q <= i_two_stop;
      end
    end
  end

  assign o_fifo_rd_req = rd_req;
  assign o_tx          = tx_q;
  assign o_busy        = (state_q != IDLE);
  assign o_done        = done_q;
  assign o_drop        = drop_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core.
// A small FWFT FIFO model feeds the core.
module tb_uart_tx_core;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        tx_en = 1'b0;
  logic [15:0] baud = '0;
  logic        pen = 1'b0;
  logic        podd = 1'b0;
  logic        two = 1'b0;
  logic        fv;
  logic [7:0]  fd;
  logic        fe;
  logic        rd_req;
  logic        tx;
  logic        busy;
  logic        done;
  logic        drop;

  logic [7:0] qd [16];
  logic       qe [16];
  int head = 0;
  int tail = 0;
  int pops = 0;
  int dones = 0;
  int drops = 0;
  int tests = 0;
  int fails = 0;

  assign fv = (head != tail);
  assign fd = qd[head[3:0]];
  assign fe = qe[head[3:0]];

  uart_tx_core #(.DW(8), .DIV_W(16)) dut (
    .i_clk               (clk),
    .i_nrst              (nrst),
    .i_tx_en             (tx_en),
    .i_baud_div          (baud),
    .i_parity_en         (pen),
    .i_parity_odd        (podd),
    .i_two_stop          (two),
    .i_fifo_valid        (fv),
    .i_fifo_data         (fd),
    .i_fifo_parity_error (fe),
    .o_fifo_rd_req       (rd_req),
    .o_tx                (tx),
    .o_busy              (busy),
    .o_done              (done),
    .o_drop              (drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_req) begin
      head <= head + 1;
      pops <= pops + 1;
    end
    if (done) dones <= dones + 1;
    if (drop) drops <= drops + 1;
  end

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    qd[tail[3:0]] = d;
    qe[tail[3:0]] = e;
    tail++;
  endtask

  function automatic void build(input logic [7:0] d, input int div,
                                input bit p_en, input bit p_odd,
                                input bit two_s,
                                output logic [255:0] w, output int n);
    bit b[$];
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (p_en) b.push_back((^d) ^ p_odd);
    b.push_back(1'b1);
    if (two_s) b.push_back(1'b1);
    w = '0;
    n = 0;
    foreach (b[j]) begin
      for (int r = 0; r <= div; r++) begin
        w[n] = b[j];
        n++;
      end
    end
  endfunction

  task automatic frame(input string tag, input logic [7:0] d,
                       input int div, input bit p_en, input bit p_odd,
                       input bit two_s, input bit now,
                       output logic [255:0] got);
    logic [255:0] e;
    int n;
    int k;
    build(d, div, p_en, p_odd, two_s, e, n);
    if (now) chk({tag, "_nogap"}, busy, 1);
    k = 0;
    while (!busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!busy) chk({tag, "_timeout"}, busy, 1);
    got = '0;
    for (int i = 0; i < n; i++) begin
      got[i] = tx;
      @(negedge clk);
    end
    chk(tag, got, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] w;
    int p0;
    int d0;
    int r0;
    int k;

    baud  = 16'd3;
    tx_en = 1'b1;
    push(8'h55, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_drop", drop, 0);
    chk("rst_rdreq", rd_req, 0);
    chk("rst_pops", pops, 0);

    nrst = 1'b1;
    frame("f55", 8'h55, 3, 0, 0, 0, 0, w);
    chk("f55_idle", busy, 0);
    chk("f55_done", done, 1);
    @(negedge clk);
    chk("f55_done_once", dones, 1);
    chk("f55_pops", pops, 1);

    tx_en = 1'b0;
    baud  = 16'd1;
    pen   = 1'b1;
    podd  = 1'b0;
    push(8'h07, 1'b0);
    tx_en = 1'b1;
    frame("p_even", 8'h07, 1, 1, 0, 0, 0, w);
    chk("p_even_bit", w[18], 1);
    podd = 1'b1;
    push(8'h07, 1'b0);
    frame("p_odd", 8'h07, 1, 1, 1, 0, 0, w);
    chk("p_odd_bit", w[18], 0);

    tx_en = 1'b0;
    baud  = 16'd0;
    pen   = 1'b1;
    podd  = 1'b0;
    two   = 1'b1;
    @(negedge clk);
    push(8'hA5, 1'b0);
    push(8'h3C, 1'b0);
    push(8'h81, 1'b0);
    p0 = pops;
    d0 = dones;
    tx_en = 1'b1;
    frame("b2b_1", 8'hA5, 0, 1, 0, 1, 0, w);
    frame("b2b_2", 8'h3C, 0, 1, 0, 1, 1, w);
    frame("b2b_3", 8'h81, 0, 1, 0, 1, 1, w);
    chk("b2b_idle", busy, 0);
    @(negedge clk);
    chk("b2b_pops", pops - p0, 3);
    chk("b2b_dones", dones - d0, 3);

    tx_en = 1'b0;
    baud  = 16'd2;
    pen   = 1'b0;
    two   = 1'b0;
    push(8'hEE, 1'b1);
    push(8'hA3, 1'b0);
    p0 = pops;
    r0 = drops;
    tx_en = 1'b1;
    @(negedge clk);
    chk("drop_pulse", drop, 1);
    chk("drop_tx", tx, 1);
    chk("drop_busy", busy, 0);
    frame("after_drop", 8'hA3, 2, 0, 0, 0, 0, w);
    @(negedge clk);
    chk("drop_count", drops - r0, 1);
    chk("drop_pops", pops - p0, 2);

    baud = 16'd3;
    push(8'h00, 1'b0);
    k = 0;
    while (!busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rst_frame_start", busy, 1);
    repeat (17) @(negedge clk);
    chk("pre_rst_tx", tx, 0);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdreq", rd_req, 0);
    p0 = pops;
    @(negedge clk);
    nrst = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_nopop", pops, p0);
    chk("post_rst_tx", tx, 1);
    tx_en = 1'b0;
    push(8'h3C, 1'b0);
    repeat (5) @(negedge clk);
    chk("post_rst_dis", pops, p0);
    chk("post_rst_busy", busy, 0);
    tx_en = 1'b1;
    frame("post_rst", 8'h3C, 3, 0, 0, 0, 0, w);

    tx_en = 1'b0;
    baud  = 16'd3;
    push(8'h96, 1'b0);
    push(8'h69, 1'b0);
    tx_en = 1'b1;
    fork
      frame("div3", 8'h96, 3, 0, 0, 0, 0, w);
      begin
        repeat (12) @(negedge clk);
        baud = 16'd7;
      end
    join
    frame("div7", 8'h69, 7, 0, 0, 0, 1, w);
    chk("div7_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data bits per frame.
REQ-002 SHALL have parameter DIV_W, default 16, meaning baud divisor width.
REQ-003 SHALL have port i_clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port i_nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_tx_en  input  1  permit new frame starts.
REQ-006 SHALL have port i_baud_div  input  DIV_W  clocks per bit minus one.
REQ-007 SHALL have port i_parity_en  input  1  append parity bit.
REQ-008 SHALL have port i_parity_odd  input  1  1=odd, 0=even parity.
REQ-009 SHALL have port i_two_stop  input  1  two stop bits when 1.
REQ-010 SHALL have port i_fifo_valid  input  1  FWFT FIFO head word valid.
REQ-011 SHALL have port i_fifo_data  input  DW  FWFT FIFO head word.
REQ-012 SHALL have port i_fifo_parity_error  input  1  head word storage parity error.
REQ-013 SHALL have port o_fifo_rd_req  output  1  pop head word, combinational.
REQ-014 SHALL have port o_tx  output  1  serial line, idle high.
REQ-015 SHALL have port o_busy  output  1  frame in progress.
REQ-016 SHALL have port o_done  output  1  one-cycle pulse per completed frame.
REQ-017 SHALL have port o_drop  output  1  one-cycle pulse per discarded corrupt word.

Function
REQ-018 SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-019 SHALL assert o_fifo_rd_req = i_tx_en && i_fifo_valid && (state==IDLE || last cycle of last STOP bit).
REQ-020 On pop with i_fifo_parity_error=0, SHALL latch data and config (div, parity_en, parity_odd, two_stop) and enter START next cycle.
REQ-021 On pop with i_fifo_parity_error=1, SHALL discard the word, pulse o_drop next cycle, and go to or remain in IDLE.
REQ-022 Each bit SHALL last exactly latched_div+1 clocks; div=0 gives one clock per bit.
REQ-023 o_tx SHALL be registered: 0 in START, data LSB first in DATA, parity in PARITY, 1 in STOP and IDLE.
REQ-024 Parity bit SHALL equal XOR(data) XOR latched_parity_odd; PARITY SHALL be skipped when parity disabled.
REQ-025 STOP SHALL last 1 or 2 bit periods per latched two_stop.
REQ-026 o_done SHALL pulse in the cycle after the last STOP cycle.
REQ-027 A pop in the last STOP cycle SHALL go directly to START with zero idle gap.
REQ-028 o_busy SHALL be 1 in every state except IDLE.
REQ-029 Input config changes mid-frame SHALL not affect the current frame.
REQ-030 Deasserting i_tx_en mid-frame SHALL let the frame complete; no further pops.
REQ-031 The bit counter SHALL be $clog2(DW) wide; DATA SHALL exit after bit DW-1.

Reset
REQ-032 While i_nrst=0: state=IDLE, o_tx=1, o_busy=0, o_done=0, o_drop=0, o_fifo_rd_req=0, all counters and latches 0.
REQ-033 Reset mid-frame SHALL abort the frame immediately; o_tx SHALL return high asynchronously.

Structure
REQ-034 The state enum typedef uart_tx_state_t SHALL reside in uart_pkg.
REQ-035 The block SHALL be a single module with no sub-module; the baud counter is inline.
REQ-036 The block SHALL sit beside uart_fifo_fwft at the top level; the FIFO's i_rd_req is driven by o_fifo_rd_req.

Verification
REQ-037 Scenario: 0x55, div=3, no parity, 1 stop -> o_tx line 0,1,0,1,0,1,0,1,0,1 LSB-first after start, 4 clocks per bit; frame is 40 clocks; one o_done.
REQ-038 Scenario: 0x07, even parity -> parity bit 1; same data, odd parity -> parity bit 0.
REQ-039 Scenario: three words queued, div=0, two_stop=1 -> frames back-to-back with no idle cycle; 3 pops, 3 o_done pulses, 12 clocks per frame.
REQ-040 Scenario: head word with i_fifo_parity_error=1 -> one pop, o_drop pulse, o_tx stays high, next word transmitted normally.
REQ-041 Scenario: i_nrst low during DATA bit 3 -> o_tx=1 and o_busy=0 immediately; after release, no pop until i_fifo_valid && i_tx_en.
REQ-042 Scenario: i_baud_div changed 3 to 7 mid-frame -> current frame keeps 4-clock bits; next frame uses 8-clock bits.
